iterative_alu: RTL

Multi-cycle execution unit that consumes the 4-bit ALU operation code produced by the ALU control stage, together with the two register/immediate operands, and returns a 32-bit result. Logic ops complete in one execute cycle. Shifts iterate one bit per cycle, and optional multiply runs as a 32-step shift-add. It sits directly downstream of ALU control, replacing the combinational ALU in the datapath. A start/busy/done handshake lets the core stall while the block runs.

---
 rtl/iterative_alu_pkg.sv | 17 +
 rtl/alu_shift_step.sv | 32 +++
 rtl/iterative_alu.sv | 82 ++++++++
 3 files changed

// File: rtl/iterative_alu_pkg.sv
// iterative_alu_pkg: shared op codes, FSM state encodings and counter width for iterative_alu
package iterative_alu_pkg;
  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_OR  = 4'b0010;
  localparam logic [3:0] ALU_AND = 4'b0011;
  localparam logic [3:0] ALU_SLL = 4'b0100;
  localparam logic [3:0] ALU_SRL = 4'b0101;
  localparam logic [3:0] ALU_MUL = 4'b1000;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam int CNT_W = 5;
  function automatic logic is_shift(input logic [3:0] op);
    return op == ALU_SLL || op == ALU_SRL;
  endfunction
endpackage

// File: rtl/alu_shift_step.sv
// alu_shift_step: one combinational iteration (shift left, shift right, or shift-add when ITERATIVE_ALU_MUL_EN)
//   en: perform a step, otherwise pass registers through; op: latched op code
//   a/b/acc: working register, multiplier, product accumulator; *_nxt: their next values
module alu_shift_step
  import iterative_alu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  en,
  input  logic [3:0]            op,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic [DATA_WIDTH-1:0] acc,
  output logic [DATA_WIDTH-1:0] a_nxt,
  output logic [DATA_WIDTH-1:0] b_nxt,
  output logic [DATA_WIDTH-1:0] acc_nxt
);
  logic mul;
`ifdef ITERATIVE_ALU_MUL_EN
  assign mul = en && op == ALU_MUL;
  assign acc_nxt = mul ? acc + (b[0] ? a : '0) : acc;
  assign b_nxt = mul ? b >> 1 : b;
`else
  assign mul = 1'b0;
  assign acc_nxt = acc;
  assign b_nxt = b;
`endif
  always_comb begin
    a_nxt = a;
    a_nxt = !en ? a : (op == ALU_SLL || mul) ? a << 1 : op == ALU_SRL ? a >> 1 : a;
  end
endmodule

// File: rtl/iterative_alu.sv
// iterative_alu: multi-cycle ALU with start/busy/done handshake; MUL enabled by ITERATIVE_ALU_MUL_EN
//   clk, reset (sync, active-low), start_i, ALU_Operation_i, A_i, B_i in;
//   busy_o, done_o (one-cycle pulse), result_o and zero_o (registered, held) out
module iterative_alu
  import iterative_alu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start_i,
  input  logic [3:0]            ALU_Operation_i,
  input  logic [DATA_WIDTH-1:0] A_i,
  input  logic [DATA_WIDTH-1:0] B_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [DATA_WIDTH-1:0] result_o,
  output logic                  zero_o
);
  logic [1:0] state;
  logic [CNT_W-1:0] cnt, cnt_load;
  logic [3:0] op_r;
  logic [DATA_WIDTH-1:0] a_r, b_r, acc, a_nxt, b_nxt, acc_nxt, res;
  logic is_mul, en, last;
`ifdef ITERATIVE_ALU_MUL_EN
  assign is_mul = op_r == ALU_MUL;
  assign cnt_load = is_shift(ALU_Operation_i) ? B_i[CNT_W-1:0] : ALU_Operation_i == ALU_MUL ? '1 : '0;
`else
  assign is_mul = 1'b0;
  assign cnt_load = is_shift(ALU_Operation_i) ? B_i[CNT_W-1:0] : '0;
`endif
  // A multiply steps on every count down to and including 0; a shift by N steps only while the count is nonzero,
  // so its final shift and the result write share the edge where the count is 1.
  assign en = is_mul || (is_shift(op_r) && cnt != '0);
  assign last = is_mul ? cnt == '0 : cnt <= 1;
  assign busy_o = state != S_IDLE;
  assign done_o = state == S_DONE;
  alu_shift_step #(.DATA_WIDTH(DATA_WIDTH)) u_step (
    .en(en), .op(op_r), .a(a_r), .b(b_r), .acc(acc),
    .a_nxt(a_nxt), .b_nxt(b_nxt), .acc_nxt(acc_nxt)
  );
  always_comb begin
    res = '0;
    res = op_r == ALU_ADD ? a_r + b_r :
          op_r == ALU_SUB ? a_r - b_r :
          op_r == ALU_OR  ? a_r | b_r :
          op_r == ALU_AND ? a_r & b_r :
          is_shift(op_r)  ? a_nxt :
          is_mul          ? acc_nxt : '0;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= S_IDLE;
      cnt <= '0;
      result_o <= '0;
      zero_o <= 1'b1;
    end else begin
      case (state)
        S_IDLE: if (start_i) begin
          state <= S_EXEC;
          op_r <= ALU_Operation_i;
          a_r <= A_i;
          b_r <= B_i;
          acc <= '0;
          cnt <= cnt_load;
        end
        S_EXEC: begin
          a_r <= a_nxt;
          b_r <= b_nxt;
          acc <= acc_nxt;
          cnt <= cnt == '0 ? cnt : cnt - 1'b1;
          if (last) begin
            result_o <= res;
            zero_o <= res == '0;
            state <= S_DONE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
